// File: rtl/alu_mul_seq_if.sv
// Bundle between the shift-and-add multiplier controller, its requester and the shared ALU.
// The slave side is the controller; the master side is the requester plus the ALU.
interface alu_mul_seq_if;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        ovf;
   logic [2:0]  alu_sel;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic [3:0]  alu_flags;

   modport slave (
      input  start, op_a, op_b, alu_result, alu_flags,
      output busy, done, product, ovf, alu_sel, alu_a, alu_b
   );

   modport master (
      output start, op_a, op_b, alu_result, alu_flags,
      input  busy, done, product, ovf, alu_sel, alu_a, alu_b
   );
endinterface

// File: rtl/alu_mul_seq.sv
// 16x16 unsigned shift-and-add multiplier that borrows the shared ALU for every add and shift.
// Returns the low 16 product bits and an exact overflow flag; stops once the multiplier runs out of set bits.
//
// state   | meaning
// IDLE    | waiting for start; ALU outputs held at zero
// CHECK   | test multiplier bit 0 through ALU AND
// ADD     | acc += mcand through ALU PLUS; fold carry and lost bits into ovf
// SHL     | mcand <<= 1; remember any bit pushed out of the top
// SHR     | mplier >>= 1; finish when it reaches zero
// DONE    | one-cycle done pulse, result stable
module alu_mul_seq (
   input  logic               clk,
   input  logic               rst_n,
   alu_mul_seq_if.slave       bus
);
   localparam logic [2:0] ALU_PLUS = 3'd0;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_SHL  = 3'd5;
   localparam logic [2:0] ALU_SHR  = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_ADD, S_SHL, S_SHR, S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] acc, acc_nxt;
   logic [15:0] mcand, mcand_nxt;
   logic [15:0] mplier, mplier_nxt;
   logic        lost, lost_nxt;
   logic        ovf_r, ovf_nxt;
   logic [2:0]  sel;
   logic [15:0] opa, opb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         lost   <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         lost   <= lost_nxt;
         ovf_r  <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      lost_nxt   = lost;
      ovf_nxt    = ovf_r;
      sel        = ALU_PLUS;
      opa        = '0;
      opb        = '0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               acc_nxt    = '0;
               mcand_nxt  = bus.op_a;
               mplier_nxt = bus.op_b;
               lost_nxt   = 1'b0;
               ovf_nxt    = 1'b0;
               state_nxt  = S_CHECK;
            end
         end
         S_CHECK: begin
            sel       = ALU_AND;
            opa       = mplier;
            opb       = 16'd1;
            state_nxt = bus.alu_flags[0] ? S_SHL : S_ADD;
         end
         S_ADD: begin
            sel       = ALU_PLUS;
            opa       = acc;
            opb       = mcand;
            acc_nxt   = bus.alu_result;
            // an add after a lost mcand bit means the true sum exceeds 16 bits
            ovf_nxt   = ovf_r | bus.alu_flags[3] | lost;
            state_nxt = S_SHL;
         end
         S_SHL: begin
            sel       = ALU_SHL;
            opa       = mcand;
            opb       = 16'd1;
            mcand_nxt = bus.alu_result;
            lost_nxt  = lost | mcand[15];
            state_nxt = S_SHR;
         end
         S_SHR: begin
            sel        = ALU_SHR;
            opa        = mplier;
            opb        = 16'd1;
            mplier_nxt = bus.alu_result;
            state_nxt  = bus.alu_flags[0] ? S_DONE : S_CHECK;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = (state == S_DONE);
   assign bus.product = acc;
   assign bus.ovf     = ovf_r;
   assign bus.alu_sel = sel;
   assign bus.alu_a   = opa;
   assign bus.alu_b   = opb;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: models the shared ALU, drives a directed vector table, corner sequences
// and random operands, and compares against arithmetic expectations for product, ovf and latency.
module tb_alu_mul_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [2:0] sel_log [0:79];

   alu_mul_seq_if bus ();
   alu_mul_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // shared ALU model: PLUS/AND/SHL/SHR with {C,O,S,Z} flags
   always_comb begin
      logic [16:0] sum;
      logic        c;
      sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      c   = 1'b0;
      case (bus.alu_sel)
         3'd0: begin bus.alu_result = sum[15:0]; c = sum[16]; end
         3'd2: bus.alu_result = bus.alu_a & bus.alu_b;
         3'd5: bus.alu_result = bus.alu_a << bus.alu_b[3:0];
         3'd6: bus.alu_result = bus.alu_a >> bus.alu_b[3:0];
         default: bus.alu_result = '0;
      endcase
      bus.alu_flags = {c, 1'b0, bus.alu_result[15], (bus.alu_result == 16'd0)};
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_len(input logic [15:0] b);
      int h = 0;
      int p = 0;
      for (int i = 0; i < 16; i++)
         if (b[i]) begin h = i; p++; end
      return 3 * (h + 1) + p;
   endfunction

   // Launch one op from IDLE and wait (bounded) for done; lat = -1 on timeout.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [15:0] p, output logic o);
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
      @(posedge clk); #1 bus.start = 1'b0;
      lat = -1; p = '0; o = 1'b0;
      for (int k = 1; k <= 75; k++) begin
         @(negedge clk);
         sel_log[k] = bus.alu_sel;
         if (bus.done) begin
            lat = k - 1; p = bus.product; o = bus.ovf;
            break;
         end
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_p;
      logic        exp_o;
      int          exp_l;
   } vec_t;

   initial begin
      vec_t        vecs [0:7];
      int          lat;
      logic [15:0] p;
      logic        o;
      int          dones;
      logic [2:0]  sel_exp [0:10];
      logic [31:0] full;
      logic [15:0] ra, rb;

      vecs[0] = '{16'd3,      16'd5,      16'd15,     1'b0, 11};
      vecs[1] = '{16'h1234,   16'h0000,   16'd0,      1'b0, 3};
      vecs[2] = '{16'h0000,   16'hFFFF,   16'd0,      1'b0, 64};
      vecs[3] = '{16'h0100,   16'h0100,   16'd0,      1'b1, 28};
      vecs[4] = '{16'hFFFF,   16'h0002,   16'hFFFE,   1'b1, 7};
      vecs[5] = '{16'h8000,   16'h0001,   16'h8000,   1'b0, 4};
      vecs[6] = '{16'd7,      16'd9,      16'd63,     1'b0, 14};
      vecs[7] = '{16'd1,      16'd1,      16'd1,      1'b0, 4};
      sel_exp = '{3'd2, 3'd0, 3'd5, 3'd6, 3'd2, 3'd5, 3'd6, 3'd2, 3'd0, 3'd5, 3'd6};

      bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_product", bus.product, 0);
      check("rst_ovf", bus.ovf, 0);
      check("rst_alu_sel", bus.alu_sel, 0);
      #20 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, lat, p, o);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_l);
         check($sformatf("vec%0d_product", i), p, vecs[i].exp_p);
         check($sformatf("vec%0d_ovf", i), o, vecs[i].exp_o);
         if (i == 0)
            for (int k = 0; k < 11; k++)
               check($sformatf("sel_seq_%0d", k), sel_log[k + 1], sel_exp[k]);
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), bus.done, 0);
         check($sformatf("vec%0d_idle", i), bus.busy, 0);
         check($sformatf("vec%0d_hold_product", i), bus.product, vecs[i].exp_p);
      end

      // reset in the 5th busy cycle of 300x300
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = 16'd300; bus.op_b = 16'd300;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_busy_before_rst", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_product", bus.product, 0);
      check("mid_rst_alu_a", bus.alu_a, 0);
      check("mid_rst_alu_sel", bus.alu_sel, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("after_rst_busy", bus.busy, 0);
      run_op(16'd300, 16'd3, lat, p, o);
      check("after_rst_product", p, 900);
      check("after_rst_latency", lat, ref_len(16'd3));
      @(negedge clk);

      // start pulsed while busy must be ignored and not queued
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = 16'd3; bus.op_b = 16'd5;
      @(posedge clk); #1 bus.start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 75; k++) begin
         @(negedge clk);
         if (k == 3) begin bus.start = 1'b1; bus.op_a = 16'd9; bus.op_b = 16'd9; end
         if (k == 4) bus.start = 1'b0;
         if (bus.done) begin lat = k - 1; p = bus.product; break; end
      end
      check("ignore_latency", lat, 11);
      check("ignore_product", p, 15);
      dones = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy) dones++;
      end
      check("ignore_not_queued", dones, 0);

      // start held high: back-to-back 7x9 runs
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = 16'd7; bus.op_b = 16'd9;
      dones = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.done) begin
            dones++;
            check($sformatf("held_done_cycle_%0d", dones), k, (dones == 1) ? 15 : 31);
            check($sformatf("held_product_%0d", dones), bus.product, 63);
         end
      end
      check("held_done_count", dones, 2);
      bus.start = 1'b0;
      lat = -1;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (!bus.busy) begin lat = k; break; end
      end
      check("held_returns_idle", (lat >= 0), 1);

      // random operands against the arithmetic reference
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 4 == 1) rb = rb >> $urandom_range(15, 4);
         if (i % 4 == 2) ra = ra >> $urandom_range(15, 4);
         full = 32'(ra) * 32'(rb);
         run_op(ra, rb, lat, p, o);
         check($sformatf("rnd%0d_product", i), p, full[15:0]);
         check($sformatf("rnd%0d_ovf", i), o, (full > 32'h0000FFFF));
         check($sformatf("rnd%0d_latency", i), lat, ref_len(rb));
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
